// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: register-file geometry
// and the latency class of an issuing instruction.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        LAT_ALU,
        LAT_LOAD,
        LAT_MUL
    } lat_class_e;

    // A multiply that is also flagged as a load is treated as a multiply.
    function automatic lat_class_e lat_class(input logic is_mul, input logic is_load);
        if (is_mul) begin
            return LAT_MUL;
        end
        if (is_load) begin
            return LAT_LOAD;
        end
        return LAT_ALU;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Saturating down-counter with a synchronous load port; one instance per tracked
// register plus one for multiplier occupancy. Load wins over the decrement.
module scoreboard_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writes and the
// multiplier, stalling ID until forwarding can supply the needed operand.
// Define SCOREBOARD_STATS_EN to add the StallCnt_o stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  IDIssue_i,
    input  logic [REG_ADDR_W-1:0] IDRs1_i,
    input  logic [REG_ADDR_W-1:0] IDRs2_i,
    input  logic                  IDUseRs1_i,
    input  logic                  IDUseRs2_i,
    input  logic                  IDRegWrite_i,
    input  logic [REG_ADDR_W-1:0] IDRd_i,
    input  logic                  IDMemRead_i,
    input  logic                  IDMul_i,
    output logic                  Stall_o
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]           StallCnt_o
`endif
);

    lat_class_e       lat_cls;
    logic [CNT_W-1:0] new_lat;
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] mul_busy;
    logic             stall;
    logic             accept;

    always_comb begin
        lat_cls = lat_class(IDMul_i, IDMemRead_i);
        new_lat = '0;
        case (lat_cls)
            LAT_MUL:  new_lat = CNT_W'(MUL_LAT);
            LAT_LOAD: new_lat = CNT_W'(LOAD_LAT);
            default:  new_lat = '0;
        endcase
    end

    // x0 is never written, so it never has anything pending.
    assign cnt[0] = '0;

    always_comb begin
        stall = 1'b0;
        if (IDIssue_i) begin
            if (IDUseRs1_i && (IDRs1_i != '0) && (cnt[IDRs1_i] != '0)) begin
                stall = 1'b1;
            end
            if (IDUseRs2_i && (IDRs2_i != '0) && (cnt[IDRs2_i] != '0)) begin
                stall = 1'b1;
            end
            if (IDMul_i && (mul_busy != '0)) begin
                stall = 1'b1;
            end
            // A younger write must not become forwardable before an older one.
            if (IDRegWrite_i && (IDRd_i != '0) && (cnt[IDRd_i] > new_lat)) begin
                stall = 1'b1;
            end
        end
    end

    assign accept  = IDIssue_i && !stall;
    assign Stall_o = stall;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        scoreboard_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (accept && IDRegWrite_i && (IDRd_i == REG_ADDR_W'(r))),
            .load_val_i (new_lat),
            .cnt_o      (cnt[r])
        );
    end

    scoreboard_counter #(
        .CNT_W (CNT_W)
    ) u_mul_busy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept && IDMul_i),
        .load_val_i (CNT_W'(MUL_LAT - 1)),
        .cnt_o      (mul_busy)
    );

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus a
// randomized run against a ready-time reference model.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 4;

    logic        clk;
    logic        rst;
    logic        iss;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        rw;
    logic [4:0]  rd;
    logic        mr;
    logic        mul;
    logic        stall;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] scnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle at which each register / the multiplier frees up.
    int now = 0;
    int ready_at [32];
    int mul_free_at = 0;
    int exp_stallcnt = 0;

    hazard_scoreboard #(
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT),
        .CNT_W    (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .IDIssue_i    (iss),
        .IDRs1_i      (rs1),
        .IDRs2_i      (rs2),
        .IDUseRs1_i   (u1),
        .IDUseRs2_i   (u2),
        .IDRegWrite_i (rw),
        .IDRd_i       (rd),
        .IDMemRead_i  (mr),
        .IDMul_i      (mul),
        .Stall_o      (stall)
`ifdef SCOREBOARD_STATS_EN
        ,
        .StallCnt_o   (scnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (ready_at[r] > now) ? ready_at[r] - now : 0;
    endfunction

    function automatic int lat_of(input logic m, input logic l);
        if (m) return MUL_LAT;
        if (l) return LOAD_LAT;
        return 0;
    endfunction

    function automatic bit exp_stall();
        if (!iss) return 1'b0;
        if (u1 && rem(int'(rs1)) > 0) return 1'b1;
        if (u2 && rem(int'(rs2)) > 0) return 1'b1;
        if (mul && mul_free_at > now) return 1'b1;
        if (rw && rem(int'(rd)) > lat_of(mul, mr)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        mul_free_at  = 0;
        exp_stallcnt = 0;
    endtask

    task automatic drive(input logic i_iss, input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                         input logic i_u1, input logic i_u2, input logic i_rw,
                         input logic [4:0] i_rd, input logic i_mr, input logic i_mul);
        iss = i_iss; rs1 = i_rs1; rs2 = i_rs2; u1 = i_u1; u2 = i_u2;
        rw = i_rw; rd = i_rd; mr = i_mr; mul = i_mul;
        #1;
    endtask

    // Advance one clock; the model commits using its own stall decision.
    task automatic tick();
        bit s;
        @(posedge clk);
        s = exp_stall();
        if (rst) begin
            if (s) exp_stallcnt++;
            if (iss && !s) begin
                if (rw && rd != 0) ready_at[rd] = now + 1 + lat_of(mul, mr);
                if (mul) mul_free_at = now + MUL_LAT;
            end
        end
        now++;
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Counts DUT stall cycles until acceptance (bounded) and model disagreements.
    task automatic wait_accept(output int n, output int mism);
        n = 0;
        mism = 0;
        for (int i = 0; i < 32; i++) begin
            if (stall !== exp_stall()) mism++;
            if (stall !== 1'b1) break;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 3, 4, 1, 1, 1, 5, 1, 1);
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
`ifdef SCOREBOARD_STATS_EN
        checks++;
        if (scnt !== 32'd0) begin
            errors++; $display("FAIL reset_stallcnt got=%0d exp=0", scnt);
        end
`endif
        tick();
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_load_use();
        int n, m;
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL load_issue stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        drive(1, 5, 1, 1, 1, 1, 6, 0, 0);
        wait_accept(n, m);
        checks++;
        if (n != LOAD_LAT || m != 0) begin
            errors++; $display("FAIL load_use stalls=%0d mism=%0d exp %0d/0", n, m, LOAD_LAT);
        end
        tick();
        idle(6);
    endtask

    task automatic test_mul_use();
        int n, m;
        drive(1, 1, 2, 1, 1, 1, 7, 0, 1);
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL mul_issue stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        drive(1, 7, 2, 1, 1, 1, 8, 0, 0);
        wait_accept(n, m);
        checks++;
        if (n != MUL_LAT || m != 0) begin
            errors++; $display("FAIL mul_use stalls=%0d mism=%0d exp %0d/0", n, m, MUL_LAT);
        end
        tick();
        idle(6);
    endtask

    task automatic test_back_to_back();
        int n, m;
        drive(1, 1, 2, 1, 1, 1, 10, 0, 1);
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL mul1_issue stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        drive(1, 3, 4, 1, 1, 1, 11, 0, 1);
        wait_accept(n, m);
        checks++;
        if (n != MUL_LAT - 1 || m != 0) begin
            errors++; $display("FAIL mul_b2b stalls=%0d mism=%0d exp %0d/0", n, m, MUL_LAT - 1);
        end
        tick();
        idle(6);
    endtask

    task automatic test_x0_and_unused();
        int n, m;
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 1, 12, 0, 0);
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL x0_consumer stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        drive(1, 0, 0, 0, 0, 1, 8, 1, 0);
        tick();
        drive(1, 1, 8, 1, 0, 1, 12, 0, 0);
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL rs2_unused stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 1, 0);
        tick();
        drive(1, 1, 9, 1, 1, 1, 12, 0, 0);
        wait_accept(n, m);
        checks++;
        if (n != 1 || m != 0) begin
            errors++; $display("FAIL rs2_used stalls=%0d mism=%0d exp 1/0", n, m);
        end
        tick();
        idle(6);
    endtask

    task automatic test_waw();
        int n, m;
        drive(1, 1, 2, 1, 1, 1, 9, 0, 1);
        tick();
        drive(1, 1, 2, 1, 1, 1, 9, 0, 0);
        wait_accept(n, m);
        checks++;
        if (n != MUL_LAT || m != 0) begin
            errors++; $display("FAIL waw_alu stalls=%0d mism=%0d exp %0d/0", n, m, MUL_LAT);
        end
        tick();
        idle(6);
        // Older load completes before a younger MUL to the same Rd: no ordering hazard.
        drive(1, 0, 0, 0, 0, 1, 13, 1, 0);
        tick();
        drive(1, 1, 2, 1, 1, 1, 13, 0, 1);
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL waw_load_mul stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        idle(6);
    endtask

    task automatic test_reset_mid();
        int n, m;
        drive(1, 1, 2, 1, 1, 1, 5, 0, 1);
        tick();
        drive(1, 5, 0, 1, 0, 1, 14, 0, 0);
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL mid_pre_reset got=%b exp=1", stall);
        end
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset_stall got=%b exp=0", stall);
        end
        tick();
        rst = 1'b1;
        #1;
`ifdef SCOREBOARD_STATS_EN
        checks++;
        if (scnt !== 32'(exp_stallcnt)) begin
            errors++; $display("FAIL mid_reset_stallcnt got=%0d exp=%0d", scnt, exp_stallcnt);
        end
`endif
        wait_accept(n, m);
        checks++;
        if (n != 0 || m != 0) begin
            errors++; $display("FAIL post_reset_consumer stalls=%0d mism=%0d exp 0/0", n, m);
        end
        tick();
        idle(6);
    endtask

    task automatic test_random();
        bit hold = 0;
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                logic m_mul, m_ld;
                m_mul = ($urandom_range(0, 99) < 15);
                m_ld  = ($urandom_range(0, 99) < 30);
                drive(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                      5'($urandom_range(0, 7)), m_ld, m_mul);
            end else begin
                #1;
            end
            checks++;
            if (stall !== exp_stall()) begin
                errors++; bad++;
                if (bad <= 10)
                    $display("FAIL random_stall cyc=%0d got=%b exp=%b", now, stall, exp_stall());
            end
            hold = exp_stall() && ($urandom_range(0, 3) != 0);
            tick();
        end
`ifdef SCOREBOARD_STATS_EN
        checks++;
        if (scnt !== 32'(exp_stallcnt)) begin
            errors++; $display("FAIL random_stallcnt got=%0d exp=%0d", scnt, exp_stallcnt);
        end
`endif
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mul_use();
        test_back_to_back();
        test_x0_and_unused();
        test_waw();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
